scoreboard_display: RTL and testbench

Receiver for the scoreboard stream produced by the RAM-side scoreboard sender. Watches the 32-bit `{userid, score}` word bus and its toggle-parity strobe, and ranks the incoming entries into a top-N leaderboard. Commits the leaderboard to a double-buffered display copy when the end-of-frame sentinel arrives. Sits between the scoreboard RAM reader and the seven-segment/LCD display driver, which reads one rank at a time.

---
 rtl/scoreboard_pkg.sv | 20 ++
 rtl/scoreboard_topn_insert.sv | 56 +++++
 rtl/scoreboard_display.sv | 151 +++++++++++++++
 tb/tb_scoreboard_display.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/scoreboard_pkg.sv
// Shared types and constants for the scoreboard stream receiver.
package scoreboard_pkg;

  localparam int          ID_W     = 16;
  localparam int          SCORE_W  = 16;
  localparam logic [31:0] SENTINEL = 32'hFFFF_FFFF;

  typedef struct packed {
    logic               valid;
    logic [ID_W-1:0]    id;
    logic [SCORE_W-1:0] score;
  } sb_entry_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    COMMIT  = 2'd2
  } sbd_state_t;

endpackage

// File: rtl/scoreboard_topn_insert.sv
// Combinational sorted insert of one entry into a top-N table.
// Slot 0 holds the best score; ties keep the earlier arrival ahead.
module scoreboard_topn_insert
  import scoreboard_pkg::*;
#(
  parameter int TOP_N = 4
) (
  input  sb_entry_t [TOP_N-1:0] tbl_i,
  input  sb_entry_t             entry_i,
  output sb_entry_t [TOP_N-1:0] tbl_o
);

  logic [TOP_N-1:0] hit_s;
  logic [TOP_N-1:0] prior_s;
  logic             seen_s;

  // Mark every slot the new entry would beat (empty, or strictly lower score)
  always_comb begin
    for (int j = 0; j < TOP_N; j++) begin
      hit_s[j] = !tbl_i[j].valid || (entry_i.score > tbl_i[j].score);
    end
  end

  // Flag slots that lie below the insertion point and therefore shift down
  always_comb begin
    seen_s = 1'b0;
    for (int j = 0; j < TOP_N; j++) begin
      prior_s[j] = seen_s;
      seen_s     = seen_s | hit_s[j];
    end
  end

  // Build the next table: keep above the insertion point, place, then shift
  always_comb begin
    tbl_o = tbl_i;
    if (entry_i.score != {SCORE_W{1'b0}}) begin
      if (hit_s[0]) begin
        tbl_o[0] = entry_i;
      end else begin
        tbl_o[0] = tbl_i[0];
      end
      for (int j = 1; j < TOP_N; j++) begin
        if (prior_s[j]) begin
          tbl_o[j] = tbl_i[j-1];
        end else if (hit_s[j]) begin
          tbl_o[j] = entry_i;
        end else begin
          tbl_o[j] = tbl_i[j];
        end
      end
    end else begin
      tbl_o = tbl_i;
    end
  end

endmodule

// File: rtl/scoreboard_display.sv
// Receives the {userid, score} word stream, ranks a frame into a top-N
// working table and commits it to a double-buffered display copy on the
// end-of-frame sentinel. The display driver reads one rank per cycle.
module scoreboard_display
  import scoreboard_pkg::*;
#(
  parameter int TOP_N   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              sb_word,
  input  logic                     sb_parity,
  input  logic [$clog2(TOP_N)-1:0] rank_sel,
  output logic [ID_W-1:0]          rank_id,
  output logic [SCORE_W-1:0]       rank_score,
  output logic                     rank_valid,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     frame_err,
  output logic [15:0]              word_count
);

  localparam int IDLE_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  sbd_state_t              state_q;
  logic                    par_q;
  sb_entry_t [TOP_N-1:0]   work_q;
  sb_entry_t [TOP_N-1:0]   disp_q;
  sb_entry_t [TOP_N-1:0]   base_tbl_s;
  sb_entry_t [TOP_N-1:0]   ins_tbl_s;
  sb_entry_t               entry_s;
  logic [15:0]             wcnt_q;
  logic [IDLE_W-1:0]       idle_q;
  logic [IDLE_W-1:0]       idle_d;
  logic                    new_word_s;
  logic                    sentinel_s;
  logic [ID_W-1:0]         rank_id_q;
  logic [SCORE_W-1:0]      rank_score_q;
  logic                    rank_valid_q;
  logic                    busy_q;
  logic                    frame_done_q;
  logic                    frame_err_q;
  logic [15:0]             word_count_q;

  assign new_word_s = sb_parity ^ par_q;
  assign sentinel_s = (sb_word == SENTINEL);
  assign idle_d     = idle_q + {{(IDLE_W-1){1'b0}}, 1'b1};

  // Form the candidate entry and pick the table it is inserted into
  always_comb begin
    entry_s.valid = 1'b1;
    entry_s.id    = sb_word[31:16];
    entry_s.score = sb_word[15:0];
    if (state_q == IDLE) begin
      base_tbl_s = '0;
    end else begin
      base_tbl_s = work_q;
    end
  end

  scoreboard_topn_insert #(
    .TOP_N (TOP_N)
  ) u_insert (
    .tbl_i   (base_tbl_s),
    .entry_i (entry_s),
    .tbl_o   (ins_tbl_s)
  );

  // Parity history runs even in reset so no spurious word follows it
  always_ff @(posedge clk) begin
    par_q <= sb_parity;
  end

  // Frame FSM, working/display tables and all registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      work_q       <= '0;
      disp_q       <= '0;
      wcnt_q       <= 16'h0000;
      idle_q       <= '0;
      rank_id_q    <= {ID_W{1'b0}};
      rank_score_q <= {SCORE_W{1'b0}};
      rank_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      word_count_q <= 16'h0000;
    end else begin
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      rank_id_q    <= disp_q[rank_sel].id;
      rank_score_q <= disp_q[rank_sel].score;
      rank_valid_q <= disp_q[rank_sel].valid;
      case (state_q)
        IDLE: begin
          // A sentinel-valued word is never treated as frame data
          if (new_word_s && !sentinel_s) begin
            work_q  <= ins_tbl_s;
            wcnt_q  <= 16'h0001;
            idle_q  <= '0;
            state_q <= COLLECT;
            busy_q  <= 1'b1;
          end else begin
            busy_q  <= 1'b0;
          end
        end
        COLLECT: begin
          if (sentinel_s) begin
            state_q <= COMMIT;
          end else if (new_word_s) begin
            work_q <= ins_tbl_s;
            idle_q <= '0;
            if (wcnt_q != 16'hFFFF) begin
              wcnt_q <= wcnt_q + 16'h0001;
            end else begin
              wcnt_q <= wcnt_q;
            end
          end else if (idle_d == IDLE_W'(TIMEOUT - 1)) begin
            frame_err_q <= 1'b1;
            state_q     <= IDLE;
            busy_q      <= 1'b0;
          end else begin
            idle_q <= idle_d;
          end
        end
        COMMIT: begin
          disp_q       <= work_q;
          word_count_q <= wcnt_q;
          frame_done_q <= 1'b1;
          state_q      <= IDLE;
          busy_q       <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign rank_id    = rank_id_q;
  assign rank_score = rank_score_q;
  assign rank_valid = rank_valid_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign frame_err  = frame_err_q;
  assign word_count = word_count_q;

endmodule

// File: tb/tb_scoreboard_display.sv
// Self-checking bench for scoreboard_display: directed scenarios plus
// randomized frames compared against a stable-sort leaderboard model.
module tb_scoreboard_display;

  localparam int TOP_N   = 4;
  localparam int TIMEOUT = 32;

  logic        clk;
  logic        rst;
  logic [31:0] sb_word;
  logic        sb_parity;
  logic [1:0]  rank_sel;
  logic [15:0] rank_id;
  logic [15:0] rank_score;
  logic        rank_valid;
  logic        busy;
  logic        frame_done;
  logic        frame_err;
  logic [15:0] word_count;

  int n_tests;
  int n_fail;

  // Reference model state
  bit          frame_open;
  int          f_ids[$];
  int          f_scores[$];
  int          f_count;
  bit          exp_valid[TOP_N];
  int          exp_id[TOP_N];
  int          exp_score[TOP_N];
  int          exp_wc;

  scoreboard_display #(
    .TOP_N   (TOP_N),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sb_word    (sb_word),
    .sb_parity  (sb_parity),
    .rank_sel   (rank_sel),
    .rank_id    (rank_id),
    .rank_score (rank_score),
    .rank_valid (rank_valid),
    .busy       (busy),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .word_count (word_count)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog
  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model_clear_display();
    for (int r = 0; r < TOP_N; r++) begin
      exp_valid[r] = 1'b0;
      exp_id[r]    = 0;
      exp_score[r] = 0;
    end
  endfunction

  // Leaderboard = N best nonzero scores, earlier arrival first among equals
  function automatic void model_commit();
    bit used[$];
    model_clear_display();
    for (int k = 0; k < f_scores.size(); k++) used.push_back(1'b0);
    for (int r = 0; r < TOP_N; r++) begin
      int best = -1;
      for (int k = 0; k < f_scores.size(); k++) begin
        if (!used[k] && f_scores[k] != 0) begin
          if (best < 0 || f_scores[k] > f_scores[best]) best = k;
        end
      end
      if (best >= 0) begin
        used[best]   = 1'b1;
        exp_valid[r] = 1'b1;
        exp_id[r]    = f_ids[best];
        exp_score[r] = f_scores[best];
      end
    end
    exp_wc     = (f_count > 65535) ? 65535 : f_count;
    frame_open = 1'b0;
  endfunction

  // Drive one word (parity toggle) at a negedge, then wait gap cycles
  task automatic send_word(input int id, input int score, input int gap);
    sb_word   = {id[15:0], score[15:0]};
    sb_parity = ~sb_parity;
    if (!frame_open) begin
      frame_open = 1'b1;
      f_ids.delete();
      f_scores.delete();
      f_count = 0;
    end
    f_ids.push_back(id);
    f_scores.push_back(score);
    f_count++;
    repeat (gap) @(negedge clk);
  endtask

  // One-cycle sentinel, optionally with a parity toggle; checks the commit
  task automatic send_sentinel(input bit toggle, input string tag);
    int  pulses;
    bit  expect_commit;
    expect_commit = frame_open;
    sb_word = 32'hFFFF_FFFF;
    if (toggle) sb_parity = ~sb_parity;
    @(negedge clk);
    sb_word = {16'h1234, 16'($urandom_range(0, 65534))};
    pulses = 0;
    repeat (5) begin
      @(negedge clk);
      if (frame_done) pulses++;
    end
    check({tag, "_done_pulses"}, pulses, expect_commit ? 1 : 0);
    check({tag, "_busy_after"}, busy, 1'b0);
    if (expect_commit) model_commit();
  endtask

  // Read every rank and compare against the model display
  task automatic check_display(input string tag);
    for (int r = 0; r < TOP_N; r++) begin
      rank_sel = r[1:0];
      @(negedge clk);
      check($sformatf("%s_valid%0d", tag, r), rank_valid, exp_valid[r]);
      if (exp_valid[r]) begin
        check($sformatf("%s_id%0d", tag, r), rank_id, exp_id[r]);
        check($sformatf("%s_score%0d", tag, r), rank_score, exp_score[r]);
      end
    end
    check({tag, "_wcnt"}, word_count, exp_wc);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_id"}, rank_id, 32'd0);
    check({tag, "_score"}, rank_score, 32'd0);
    check({tag, "_valid"}, rank_valid, 32'd0);
    check({tag, "_busy"}, busy, 32'd0);
    check({tag, "_done"}, frame_done, 32'd0);
    check({tag, "_err"}, frame_err, 32'd0);
    check({tag, "_wcnt"}, word_count, 32'd0);
  endtask

  initial begin
    int pulses;
    n_tests    = 0;
    n_fail     = 0;
    frame_open = 1'b0;
    f_count    = 0;
    exp_wc     = 0;
    model_clear_display();
    rst       = 1'b1;
    sb_word   = 32'h0;
    sb_parity = 1'b0;
    rank_sel  = 2'd0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Basic ranking with ties
    send_word(0, 50, 3);
    send_word(1, 80, 3);
    check("busy_in_frame", busy, 1'b1);
    send_word(2, 10, 3);
    send_word(3, 80, 3);
    send_word(4, 30, 3);
    send_sentinel(1'b0, "basic");
    check_display("basic");
    check("basic_wc_is5", word_count, 32'd5);

    // Zero scores are counted but never ranked
    send_word(0, 0, 3);
    send_word(1, 0, 3);
    send_word(2, 7, 3);
    send_sentinel(1'b1, "zero");
    check_display("zero");

    // Timeout abort leaves the previous display in place
    send_word(9, 900, 3);
    send_word(8, 800, 1);
    pulses = 0;
    repeat (TIMEOUT + 6) begin
      @(negedge clk);
      if (frame_err) pulses++;
    end
    check("timeout_err_pulses", pulses, 32'd1);
    check("timeout_busy", busy, 1'b0);
    frame_open = 1'b0;
    check_display("after_timeout");

    // Sentinel with simultaneous toggle: word dropped, not counted
    send_word(5, 20, 3);
    send_word(6, 40, 3);
    send_sentinel(1'b1, "simul");
    check_display("simul");
    check("simul_wc_is2", word_count, 32'd2);
    // Sentinel level while idle must not commit
    send_sentinel(1'b0, "idle_sentinel");
    check_display("idle_sentinel");

    // Reset in the middle of a frame
    send_word(11, 111, 3);
    send_word(12, 222, 3);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_all_zero("midreset");
    rst = 1'b0;
    frame_open = 1'b0;
    exp_wc     = 0;
    model_clear_display();
    @(negedge clk);
    check("midreset_no_frame", busy, 1'b0);
    send_word(13, 3, 3);
    send_word(14, 9, 3);
    send_word(15, 6, 3);
    send_sentinel(1'b0, "post_reset");
    check_display("post_reset");

    // Randomized frames with ties, zeros and back-to-back words
    for (int f = 0; f < 25; f++) begin
      int nw;
      nw = $urandom_range(1, 10);
      for (int w = 0; w < nw; w++) begin
        int sc;
        sc = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 12);
        send_word($urandom_range(0, 65535), sc, $urandom_range(1, 5));
      end
      send_sentinel($urandom_range(0, 1) == 1, $sformatf("rnd%0d", f));
      check_display($sformatf("rnd%0d", f));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
